cpu_state_dump: RTL and testbench

Hardware counterpart of the per-cycle CPU state printout. It counts executed cycles, stalls and flushes. On a snapshot request it freezes the pipelined CPU and streams a fixed 44-word frame over a valid/ready interface: counters, PC, R0–R31, data memory 0x00–0x1c. It sits beside `CPU`, taps the register-file and data-memory debug read ports, and drives the pipeline hold input.

---
 rtl/cpu_dump_pkg.sv | 20 ++
 rtl/cpu_state_dump_counter.sv | 23 ++
 rtl/cpu_state_dump.sv | 143 ++++++++++++++
 tb/tb_cpu_state_dump.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dump_pkg.sv
`default_nettype none
// cpu_dump_pkg: shared state encoding and frame layout for the CPU state dump.
// Rev 1.0
package cpu_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    REG  = 2'd2,
    MEM  = 2'd3
  } dump_state_e;

  localparam int FRAME_LEN = 44;
  localparam int HDR_BASE  = 0;
  localparam int REG_BASE  = 4;
  localparam int MEM_BASE  = 36;
  localparam int IDX_W     = 6;

endpackage
`default_nettype wire

// File: rtl/cpu_state_dump_counter.sv
`default_nettype none
// dump_counter: wrapping up-counter with synchronous clear and enable.
// Rev 1.0
module dump_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  // count_next is exposed so a snapshot can capture the post-edge value.
  assign count_next = en ? count + WIDTH'(1) : count;

  always_ff @(posedge clk) begin
    if (clr) count <= '0;
    else     count <= count_next;
  end

endmodule
`default_nettype wire

// File: rtl/cpu_state_dump.sv
`default_nettype none
// cpu_state_dump: counts run/stall/flush cycles; on request freezes the CPU and
// streams a 44-word frame (counters, PC, R0-R31, M[0x00..0x1c]). Rev 1.0
module cpu_state_dump
  import cpu_dump_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int DMEM_WORDS = 8,
  parameter int DATA_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          pc_i,
  input  logic                       snap_i,
  output logic [$clog2(REG_NUM)-1:0] rf_addr_o,
  input  logic [DATA_W-1:0]          rf_data_i,
  output logic [DATA_W-1:0]          dm_addr_o,
  input  logic [DATA_W-1:0]          dm_data_i,
  output logic                       freeze_o,
  output logic                       busy_o,
  output logic                       dump_valid_o,
  input  logic                       dump_ready_i,
  output logic [DATA_W-1:0]          dump_data_o,
  output logic                       dump_last_o
);

  localparam int RF_AW = $clog2(REG_NUM);
  localparam logic [IDX_W-1:0] HDR_IDX  = IDX_W'(HDR_BASE);
  localparam logic [IDX_W-1:0] REG_IDX  = IDX_W'(REG_BASE);
  localparam logic [IDX_W-1:0] MEM_IDX  = IDX_W'(MEM_BASE);
  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(REG_BASE - 1);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_BASE + REG_NUM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_BASE + DMEM_WORDS - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(FRAME_LEN);

  dump_state_e       state;
  logic [IDX_W-1:0]  idx;
  logic              busy;
  logic [DATA_W-1:0] snap_cycle, snap_stall, snap_flush, snap_pc;
  logic [DATA_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [DATA_W-1:0] cycle_next, stall_next, flush_next;
  logic [DATA_W-1:0] word;
  logic              run_en;
  logic              load;
  logic              handshake;
  logic [IDX_W-1:0]  hdr_off;

  assign freeze_o = busy;
  assign busy_o   = busy;
  assign run_en   = start_i && !freeze_o;

  dump_counter #(.WIDTH(DATA_W)) u_cycle_cnt (
    .clk(clk_i), .clr(rst_i), .en(run_en),
    .count(cycle_cnt), .count_next(cycle_next)
  );

  dump_counter #(.WIDTH(DATA_W)) u_stall_cnt (
    .clk(clk_i), .clr(rst_i), .en(run_en && stall_i),
    .count(stall_cnt), .count_next(stall_next)
  );

  dump_counter #(.WIDTH(DATA_W)) u_flush_cnt (
    .clk(clk_i), .clr(rst_i), .en(run_en && flush_i),
    .count(flush_cnt), .count_next(flush_next)
  );

  assign handshake = dump_valid_o && dump_ready_i;
  assign load      = (state != IDLE) && (idx < END_IDX) && (!dump_valid_o || dump_ready_i);

  assign rf_addr_o = (state == REG) ? RF_AW'(idx - REG_IDX) : '0;
  assign dm_addr_o = (state == MEM) ? DATA_W'({idx - MEM_IDX, 2'b00}) : '0;
  assign hdr_off   = idx - HDR_IDX;

  always_comb begin
    word = '0;
    case (state)
      HDR: begin
        case (hdr_off[1:0])
          2'd0:    word = snap_cycle;
          2'd1:    word = snap_stall;
          2'd2:    word = snap_flush;
          default: word = snap_pc;
        endcase
      end
      REG:     word = rf_data_i;
      MEM:     word = dm_data_i;
      default: word = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      snap_cycle   <= '0;
      snap_stall   <= '0;
      snap_flush   <= '0;
      snap_pc      <= '0;
      dump_valid_o <= 1'b0;
      dump_data_o  <= '0;
      dump_last_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_i) begin
            state      <= HDR;
            idx        <= '0;
            busy       <= 1'b1;
            snap_cycle <= cycle_next;
            snap_stall <= stall_next;
            snap_flush <= flush_next;
            snap_pc    <= pc_i;
          end
        end
        HDR: if (load && idx == HDR_LAST) state <= REG;
        REG: if (load && idx == REG_LAST) state <= MEM;
        MEM: begin
          if (handshake && dump_last_o) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // A new word may replace the current one only once it has been taken.
      if (load) begin
        dump_data_o  <= word;
        dump_last_o  <= (idx == LAST_IDX);
        dump_valid_o <= 1'b1;
        idx          <= idx + IDX_W'(1);
      end else if (handshake) begin
        dump_valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_state_dump.sv
`default_nettype none
// tb_cpu_state_dump: vector table plus scoreboard bench for cpu_state_dump.
module tb_cpu_state_dump;

  logic        clk = 1'b0;
  logic        rst, start, stall, flush, snap;
  logic [31:0] pc;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, dm_addr, dm_data;
  logic        freeze, busy, dump_valid, dump_ready, dump_last;
  logic [31:0] dump_data;

  logic [31:0] rf  [32];
  logic [7:0]  mem [32];
  logic [4:0]  dm_a;

  always #5 clk = ~clk;

  assign dm_a    = dm_addr[4:0];
  assign rf_data = rf[rf_addr];
  assign dm_data = {mem[5'(dm_a + 5'd3)], mem[5'(dm_a + 5'd2)], mem[5'(dm_a + 5'd1)], mem[dm_a]};

  cpu_state_dump dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .snap_i(snap), .rf_addr_o(rf_addr), .rf_data_i(rf_data),
    .dm_addr_o(dm_addr), .dm_data_i(dm_data), .freeze_o(freeze), .busy_o(busy),
    .dump_valid_o(dump_valid), .dump_ready_i(dump_ready), .dump_data_o(dump_data),
    .dump_last_o(dump_last)
  );

  typedef struct packed {logic [31:0] data; logic last;} word_t;
  word_t exp_q[$];

  int checks = 0;
  int passes = 0;
  int ready_pct = 100;
  int words_seen = 0, lasts_seen = 0, fz_len = 0, bp = 0, last_fz_len = 0, last_bp = 0;
  logic        prev_stall = 1'b0, prev_fz = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Scoreboard / stream monitor; ready is chosen here so the handshake decision
  // uses exactly the values the DUT will see at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      words_seen = 0; fz_len = 0; bp = 0;
      prev_stall = 1'b0; prev_fz = 1'b0; dump_ready = 1'b0;
    end else begin
      if (prev_stall)
        chk("stable_hold", {dump_valid, dump_data, dump_last}, {1'b1, prev_data, prev_last});
      dump_ready = ($urandom_range(99) < ready_pct);
      if (freeze) fz_len++;
      else if (prev_fz) begin
        last_fz_len = fz_len; last_bp = bp; fz_len = 0; bp = 0;
      end
      prev_fz = freeze;
      if (dump_valid && !dump_ready) bp++;
      prev_stall = dump_valid && !dump_ready;
      prev_data  = dump_data;
      prev_last  = dump_last;
      if (dump_valid && dump_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {dump_data, dump_last}, 33'h0);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk($sformatf("word_idx%0d", words_seen), {dump_data, dump_last}, e);
        end
        words_seen++;
        if (dump_last) begin
          lasts_seen++;
          words_seen = 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; snap = 1'b0;
    exp_q.delete();
    repeat (2) tick;
    rst = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] c, input logic [31:0] s, input logic [31:0] f);
    word_t w;
    w = '{c, 1'b0}; exp_q.push_back(w);
    w = '{s, 1'b0}; exp_q.push_back(w);
    w = '{f, 1'b0}; exp_q.push_back(w);
    w = '{pc, 1'b0}; exp_q.push_back(w);
    for (int r = 0; r < 32; r++) begin
      w = '{rf[r], 1'b0}; exp_q.push_back(w);
    end
    for (int m = 0; m < 8; m++) begin
      w = '{{mem[4*m+3], mem[4*m+2], mem[4*m+1], mem[4*m]}, m == 7};
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_idle(input string what);
    int n = 0;
    while (busy && n < 2000) begin
      tick;
      n++;
    end
    chk({what, "_idle_timeout"}, busy, 0);
  endtask

  task automatic wait_words(input int target);
    int n = 0;
    while (words_seen < target && n < 500) begin
      tick;
      n++;
    end
    chk("reach_word_timeout", words_seen >= target, 1);
  endtask

  // Snapshot, optionally keep the CPU "running" while frozen, then check
  // the freeze length against the back-pressure seen.
  task automatic snap_and_wait(input logic [31:0] c, input logic [31:0] s,
                               input logic [31:0] f, input bit run);
    push_frame(c, s, f);
    snap = 1'b1;
    tick;
    snap = 1'b0;
    chk("busy_after_snap", {busy, freeze}, 2'b11);
    if (run) start = 1'b1;
    wait_idle("frame");
    start = 1'b0;
    tick;
    chk("freeze_len", last_fz_len, 45 + last_bp);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    int          n;
    logic [15:0] stall_m;
    logic [15:0] flush_m;
    int          rdy;
    logic [31:0] pcv;
    logic [31:0] ec, es, ef;
  } vec_t;
  vec_t tbl [3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lasts0;
    tbl[0] = '{10, 16'b0000_0000_0010_0101, 16'b0000_0000_1000_0100, 100, 32'h0000_1000, 32'd10, 32'd3, 32'd2};
    tbl[1] = '{5, 16'h0000, 16'h001F, 30, 32'hDEAD_BEE0, 32'd5, 32'd0, 32'd5};
    tbl[2] = '{16, 16'hFFFF, 16'h0001, 30, 32'h0000_0004, 32'd16, 32'd16, 32'd1};

    for (int i = 0; i < 32; i++) begin
      rf[i]  = $urandom;
      mem[i] = 8'($urandom);
    end
    rf[0] = '0; rf[8] = 32'd5; rf[31] = 32'hFFFF_FFFF;
    mem[0] = 8'h05; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    mem[4] = 8'h78; mem[5] = 8'h56; mem[6] = 8'h34; mem[7] = 8'h12;
    pc = 32'h0;

    do_reset;
    chk("rst_freeze_busy", {freeze, busy}, 2'b00);
    chk("rst_valid_last", {dump_valid, dump_last}, 2'b00);
    chk("rst_data", dump_data, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_dm_addr", dm_addr, 0);

    for (int v = 0; v < 3; v++) begin
      do_reset;
      ready_pct = tbl[v].rdy;
      pc = tbl[v].pcv;
      for (int k = 0; k < tbl[v].n; k++) begin
        start = 1'b1;
        stall = tbl[v].stall_m[k];
        flush = tbl[v].flush_m[k];
        tick;
      end
      start = 1'b0; stall = 1'b0; flush = 1'b0;
      snap_and_wait(tbl[v].ec, tbl[v].es, tbl[v].ef, 1'b1);
      if (tbl[v].rdy == 100) chk("freeze_45", last_fz_len, 45);
      // Counters must not have moved while frozen, so the header repeats.
      snap_and_wait(tbl[v].ec, tbl[v].es, tbl[v].ef, 1'b0);
    end

    // Snap while busy is ignored.
    do_reset;
    ready_pct = 100;
    pc = 32'h0000_0200;
    start = 1'b1;
    repeat (4) tick;
    start = 1'b0;
    lasts0 = lasts_seen;
    push_frame(32'd4, 32'd0, 32'd0);
    snap = 1'b1;
    tick;
    snap = 1'b0;
    wait_words(10);
    snap = 1'b1;
    tick;
    snap = 1'b0;
    wait_idle("busy_snap");
    repeat (3) tick;
    chk("one_frame_only", lasts_seen - lasts0, 1);
    chk("no_extra_words", {exp_q.size(), busy}, {32'd0, 1'b0});
    snap_and_wait(32'd4, 32'd0, 32'd0, 1'b0);

    // Reset in the middle of a frame.
    ready_pct = 100;
    start = 1'b1;
    repeat (7) tick;
    start = 1'b0;
    lasts0 = lasts_seen;
    push_frame(32'd11, 32'd0, 32'd0);
    snap = 1'b1;
    tick;
    snap = 1'b0;
    wait_words(20);
    rst = 1'b1;
    exp_q.delete();
    tick;
    rst = 1'b0;
    chk("midrst_valid", dump_valid, 0);
    chk("midrst_freeze", freeze, 0);
    repeat (5) tick;
    chk("midrst_no_last", lasts_seen, lasts0);
    snap_and_wait(32'd0, 32'd0, 32'd0, 1'b0);

    // Counter wrap.
    do_reset;
    @(negedge clk);
    force dut.u_cycle_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_cycle_cnt.count;
    tick;
    start = 1'b1;
    repeat (3) tick;
    start = 1'b0;
    snap_and_wait(32'd1, 32'd0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
